// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = stream source / memory side, slave = the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit LE words for the
// instruction memory and holds the core in reset until done. Optional trailing
// XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  imem_loader_if.slave bus,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam logic [16:0] MAX_N = 17'(MEM_WORDS);

  state_e            state_q;
  logic [15:0]       n_q;
  logic [15:0]       idx_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       asm_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              core_rst_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              ready;
  logic              accept;
  logic [15:0]       n_hdr_d;
  logic [31:0]       word_d;
  logic              last_word;

  assign ready     = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept    = bus.in_valid && ready;
  assign n_hdr_d   = {bus.in_data, n_q[7:0]};
  // Bytes arrive LSB first, so the newest byte is always the top of the word.
  assign word_d    = {bus.in_data, asm_q};
  assign last_word = (idx_q == n_q - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR0;
      n_q         <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_HDR0: begin
          if (accept) begin
            n_q[7:0] <= bus.in_data;
            busy_q   <= 1'b1;
            state_q  <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (accept) begin
            n_q        <= n_hdr_d;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            if (n_hdr_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q    <= S_CSUM;
`else
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              core_rst_q <= 1'b0;
`endif
            end else if ({1'b0, n_hdr_d} > MAX_N) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.in_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= idx_q[ADDR_W-1:0];
              mem_wdata_q <= word_d;
              idx_q       <= idx_q + 16'd1;
              byte_cnt_q  <= '0;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_q    <= S_CSUM;
`else
                state_q    <= S_DONE;
                done_q     <= 1'b1;
                busy_q     <= 1'b0;
                core_rst_q <= 1'b0;
`endif
              end
            end else begin
              asm_q      <= {bus.in_data, asm_q[23:8]};
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) begin
            busy_q <= 1'b0;
            if (bus.in_data == csum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              core_rst_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
`else
          state_q <= S_ERR;
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
`endif
        end
        S_DONE: state_q <= S_DONE;
        S_ERR:  state_q <= S_ERR;
        default: begin
          state_q <= S_ERR;
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rst      = core_rst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven byte stream plus directed
// corner cases (bad header, empty image, mid-load reset, optional checksum).
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic core_rst, busy, done, err;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .MEM_WORDS(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        rdy, bsy, dn, crst, er, we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[11];
  int   nvec;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  // Write log captured mid-cycle: a strobe wider than one cycle shows up twice.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic bsy,
                              input logic dn, input logic crst, input logic er,
                              input logic we);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
    check({tag, ".busy"},     32'(busy),         32'(bsy));
    check({tag, ".done"},     32'(done),         32'(dn));
    check({tag, ".core_rst"}, 32'(core_rst),     32'(crst));
    check({tag, ".err"},      32'(err),          32'(er));
    check({tag, ".mem_we"},   32'(bus.mem_we),   32'(we));
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic rdy, input logic bsy,
                              input logic dn, input logic crst, input logic er,
                              input logic we, input logic [7:0] a, input logic [31:0] w);
    vec_t v;
    v.data = d; v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.crst = crst;
    v.er = er; v.we = we; v.addr = a; v.wdata = w;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Idle for gap cycles (with junk on in_data), then present the byte for one edge.
  task automatic send_byte(input logic [7:0] d, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hFF;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    $display("sent byte 0x%02h gap=%0d -> we=%0b addr=%0d wdata=0x%08h busy=%0b done=%0b err=%0b",
             d, gap, bus.mem_we, bus.mem_addr, bus.mem_wdata, busy, done, err);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Stream 02 00 | 13 05 A0 00 | 93 05 B0 00 [| 90]; 0x90 = XOR of data bytes.
    vecs[0]  = mk(8'h02, 1, 1, 0, 1, 0, 0, 8'd0, 32'h0);
    vecs[1]  = mk(8'h00, 1, 1, 0, 1, 0, 0, 8'd0, 32'h0);
    vecs[2]  = mk(8'h13, 1, 1, 0, 1, 0, 0, 8'd0, 32'h0);
    vecs[3]  = mk(8'h05, 1, 1, 0, 1, 0, 0, 8'd0, 32'h0);
    vecs[4]  = mk(8'hA0, 1, 1, 0, 1, 0, 0, 8'd0, 32'h0);
    vecs[5]  = mk(8'h00, 1, 1, 0, 1, 0, 1, 8'd0, 32'h00A00513);
    vecs[6]  = mk(8'h93, 1, 1, 0, 1, 0, 0, 8'd0, 32'h00A00513);
    vecs[7]  = mk(8'h05, 1, 1, 0, 1, 0, 0, 8'd0, 32'h00A00513);
    vecs[8]  = mk(8'hB0, 1, 1, 0, 1, 0, 0, 8'd0, 32'h00A00513);
    vecs[9]  = mk(8'h00, CK, CK, !CK, CK, 0, 1, 8'd1, 32'h00B00593);
    vecs[10] = mk(8'h90, 0, 0, 1, 0, 0, 0, 8'd1, 32'h00B00593);
    nvec = CK ? 11 : 10;

    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      check_status($sformatf("reset%0d", pass), 1, 0, 0, 1, 0, 0);
      check($sformatf("reset%0d.mem_addr", pass),  32'(bus.mem_addr), 32'h0);
      check($sformatf("reset%0d.mem_wdata", pass), bus.mem_wdata,     32'h0);
      for (int i = 0; i < nvec; i++) begin
        send_byte(vecs[i].data, pass * 3);
        check_status($sformatf("p%0d[%0d]", pass, i), vecs[i].rdy, vecs[i].bsy,
                     vecs[i].dn, vecs[i].crst, vecs[i].er, vecs[i].we);
        check($sformatf("p%0d[%0d].mem_addr", pass, i),  32'(bus.mem_addr), 32'(vecs[i].addr));
        check($sformatf("p%0d[%0d].mem_wdata", pass, i), bus.mem_wdata,     vecs[i].wdata);
      end
      settle();
      check($sformatf("p%0d.write_count", pass), 32'(wr_addr_q.size()), 32'd2);
      if (wr_addr_q.size() == 2) begin
        check($sformatf("p%0d.w0_addr", pass), 32'(wr_addr_q[0]), 32'd0);
        check($sformatf("p%0d.w0_data", pass), wr_data_q[0], 32'h00A00513);
        check($sformatf("p%0d.w1_addr", pass), 32'(wr_addr_q[1]), 32'd1);
        check($sformatf("p%0d.w1_data", pass), wr_data_q[1], 32'h00B00593);
      end
      check_status($sformatf("p%0d.final", pass), 0, 0, 1, 0, 0, 0);
    end

    // N = 257 exceeds the memory: error right after the second header byte.
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check_status("n257", 0, 0, 0, 1, 1, 0);
    send_byte(8'h55, 0);
    check_status("n257.sticky", 0, 0, 0, 1, 1, 0);
    settle();
    check("n257.write_count", 32'(wr_addr_q.size()), 32'd0);

    // N = 256 is exactly the memory depth and must be accepted.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    check_status("n256", 1, 1, 0, 1, 0, 0);

    // N = 0: empty image (still needs the 0x00 checksum byte when enabled).
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_status("n0.hdr", CK, CK, !CK, CK, 0, 0);
    if (CK) begin
      send_byte(8'h00, 0);
      check_status("n0.csum", 0, 0, 1, 0, 0, 0);
    end
    settle();
    check("n0.write_count", 32'(wr_addr_q.size()), 32'd0);

    // Reset after 6 data bytes, then a fresh 1-word image.
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 2; i < 8; i++) send_byte(vecs[i].data, 0);
    do_reset();
    check_status("midrst", 1, 0, 0, 1, 0, 0);
    check("midrst.mem_addr", 32'(bus.mem_addr), 32'h0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 1);
    send_byte(8'h12, 0);
    check_status("midrst.last", CK, CK, !CK, CK, 0, 1);
    check("midrst.wdata", bus.mem_wdata, 32'h12345678);
    if (CK) begin
      send_byte(8'h08, 0);
      check_status("midrst.csum", 0, 0, 1, 0, 0, 0);
    end
    settle();
    check("midrst.write_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("midrst.w0_addr", 32'(wr_addr_q[0]), 32'd0);
      check("midrst.w0_data", wr_data_q[0], 32'h12345678);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good (0xB6) and bad (0x00) for the 1-word image 13 05 A0 00.
    for (int c = 0; c < 2; c++) begin
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      send_byte(8'hA0, 0);
      send_byte(8'h00, 0);
      send_byte((c == 0) ? 8'hB6 : 8'h00, 0);
      if (c == 0) check_status("csum.good", 0, 0, 1, 0, 0, 0);
      else        check_status("csum.bad",  0, 0, 0, 1, 1, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
